rob_param: RTL
==============

Name: rob_param

Overview:
- Parametrised reorder buffer for the Tomasulo core. It generalises the hard-wired 8-entry ROB arrays into a self-contained block.
- Allocates entries in program order at issue and accepts results from WB_PORTS common-data-bus channels in any order.
- Retires strictly in order to the register file through a valid/ready commit handshake.
- Provides two operand-lookup ports for rename-time forwarding, and supports a full flush.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- TAG_W, $clog2(DEPTH), width of an entry tag (ROB pointer).
- DATA_W, 8, result value width.
- REG_AW, 4, architectural register index width.
- OP_W, 4, opcode width.
- WB_PORTS, 2, number of CDB writeback channels.
- OP_STORE, 4'b0100, opcode whose commit does not write a register.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries.
- alloc_valid  in  1  issue stage requests an entry.
- alloc_ready  out  1  an entry is available (!full).
- alloc_opcode  in  OP_W  opcode of the instruction being allocated.
- alloc_dest  in  REG_AW  destination register.
- alloc_tag  out  TAG_W  tag that will be assigned (equals tail).
- wb_valid  in  WB_PORTS  per-channel result strobe.
- wb_tag  in  WB_PORTS*TAG_W  per-channel tag, packed.
- wb_value  in  WB_PORTS*DATA_W  per-channel result, packed.
- look_tag  in  2*TAG_W  lookup tags, packed.
- look_done  out  2  the looked-up entry has its result.
- look_value  out  2*DATA_W  the looked-up result.
- commit_valid  out  1  the head entry is done.
- commit_ready  in  1  the register file accepts the commit.
- commit_we  out  1  commit writes a register (opcode != OP_STORE).
- commit_dest  out  REG_AW  destination register of the head entry.
- commit_value  out  DATA_W  result of the head entry.
- commit_tag  out  TAG_W  head pointer.
- count  out  TAG_W+1  number of occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset values, taking effect on the edge after rst=1:
  - head=tail=0, count=0, all busy/done bits 0.
  - empty=1, full=0, alloc_ready=1, commit_valid=0.
  - look_done=0, alloc_tag=0, commit_we=0, commit_tag=0.
- Reset applied mid-operation discards everything in flight; no commit fires in that cycle.
- Allocate fires when alloc_valid && alloc_ready:
  - entry[tail] is loaded with busy=1, done=0, the opcode and the dest.
  - tail advances modulo DEPTH (wraps DEPTH-1 -> 0).
- alloc_ready is derived from registered count only. When full, an allocate is refused even if a commit fires in the same cycle (no same-cycle slot reuse).
- Writeback: for each channel with wb_valid, if entry[wb_tag] is busy and not yet done, the edge sets done=1 and stores the value.
  - A writeback to a non-busy entry is ignored.
  - A duplicate writeback to a done entry is ignored; the first value is kept.
  - If two channels target the same tag in one cycle, the lower channel index wins.
- Commit is combinational from the head entry: commit_valid = !empty && done[head].
  - It fires when commit_valid && commit_ready: busy[head] clears and head advances modulo DEPTH.
  - A writeback to the head entry makes it committable in the next cycle, not the same cycle (1-cycle minimum from WB to commit).
- count changes by +1 on allocate, -1 on commit, and is unchanged when both fire in the same cycle.
- Lookup is combinational:
  - look_done = busy && (done || a same-cycle writeback hit to that tag).
  - look_value is taken from the writeback bus when bypassed, otherwise from the stored entry.
  - A lookup of a non-busy tag returns look_done=0 and look_value=0.
- Flush has priority over allocate, writeback and commit in the same cycle. The next state equals the reset state, and commit_valid is forced to 0 during the flush cycle.
- With rst or flush asserted, no other input has any effect.

Decomposition:
- rob_pkg holds:
  - opcode constants: OP_SUB=0, OP_ADD=1, OP_MUL=2, OP_DIV=3, OP_STORE=4, OP_LOAD=5;
  - the rob_entry_t struct {busy, done, opcode, dest, value};
  - the function for the TAG_W default.
- One sub-module is natural: rob_wb_arbiter. It resolves the per-entry writeback hits across WB_PORTS with lowest-index priority, and its hit vector is reused by the lookup bypass.

Test Plan:
- Reset, then allocate 8 entries (dests 1..8) -> alloc_tag sequence 0..7, full=1, alloc_ready=0, count=8.
- Out-of-order writeback: WB tag2=0x22, then tag0=0x10, then tag1=0x11, commit_ready=1 -> commits in order 0,1,2 with values 0x10,0x11,0x22; no commit before tag0 completes.
- Wrap-around and concurrency:
  - Fill the buffer, commit 3, allocate 3 -> tags 0,1,2 reused.
  - Allocate and commit in the same cycle at count=5 -> count stays 5.
- Store entry: allocate opcode 4'b0100 dest 3 and complete it -> commit_valid=1, commit_we=0.
- Writeback conflicts and bypass:
  - Same-cycle WB on both channels to tag4 (0xAA on ch0, 0xBB on ch1) -> stored value is 0xAA.
  - A lookup of tag4 in that cycle -> look_done=1, look_value=0xAA.
- Flush with 5 entries pending and simultaneous alloc/WB/commit -> next cycle empty=1, count=0, tail=head=0, and none of the concurrent operations take effect.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and constants for the parametrised reorder buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rob_pkg;

  // Default field widths of the standard core configuration.
  localparam int ROB_DATA_W = 8;
  localparam int ROB_REG_AW = 4;
  localparam int ROB_OP_W   = 4;

  // Opcode encoding of the Tomasulo core.
  localparam logic [ROB_OP_W-1:0] OP_SUB   = 4'd0;
  localparam logic [ROB_OP_W-1:0] OP_ADD   = 4'd1;
  localparam logic [ROB_OP_W-1:0] OP_MUL   = 4'd2;
  localparam logic [ROB_OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [ROB_OP_W-1:0] OP_STORE = 4'd4;
  localparam logic [ROB_OP_W-1:0] OP_LOAD  = 4'd5;

  // One ROB slot in the default configuration.
  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [ROB_OP_W-1:0]   opcode;
    logic [ROB_REG_AW-1:0] dest;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry_t;

  // Tag width for a given depth; never narrower than one bit.
  function automatic int rob_tag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rob_wb_arbiter.sv
// Maps the CDB writeback channels onto per-entry hits, lowest channel wins.
// Latency: purely combinational.
// Backpressure: none; every channel is always accepted here, filtering happens in the ROB.
module rob_wb_arbiter
  import rob_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 8,
  parameter int WB_PORTS = 2
) (
  input  logic [WB_PORTS-1:0]        wb_valid_i,
  input  logic [WB_PORTS*TAG_W-1:0]  wb_tag_i,
  input  logic [WB_PORTS*DATA_W-1:0] wb_value_i,
  output logic [DEPTH-1:0]           hit_o,
  output logic [DEPTH*DATA_W-1:0]    hit_value_o
);

  // Scan channels from highest to lowest so the lowest index overwrites last.
  always_comb begin
    hit_o       = '0;
    hit_value_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && (wb_tag_i[p*TAG_W +: TAG_W] == TAG_W'(e))) begin
          hit_o[e]                         = 1'b1;
          hit_value_o[e*DATA_W +: DATA_W]  = wb_value_i[p*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order alloc, out-of-order CDB writeback, in-order commit.
// Latency: WB to commit >= 1 cycle; lookups bypass same-cycle writebacks combinationally.
// Backpressure: alloc_ready from registered count only; commit held until commit_ready.
module rob_param #(
  parameter int DEPTH    = 8,
  parameter int TAG_W    = rob_pkg::rob_tag_w(DEPTH),
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 4,
  parameter int OP_W     = 4,
  parameter int WB_PORTS = 2,
  parameter logic [OP_W-1:0] OP_STORE = 4'b0100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [OP_W-1:0]            alloc_opcode,
  input  logic [REG_AW-1:0]          alloc_dest,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]  wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0] wb_value,
  input  logic [2*TAG_W-1:0]         look_tag,
  output logic [1:0]                 look_done,
  output logic [2*DATA_W-1:0]        look_value,
  output logic                       commit_valid,
  input  logic                       commit_ready,
  output logic                       commit_we,
  output logic [REG_AW-1:0]          commit_dest,
  output logic [DATA_W-1:0]          commit_value,
  output logic [TAG_W-1:0]           commit_tag,
  output logic [TAG_W:0]             count,
  output logic                       empty,
  output logic                       full
);
  import rob_pkg::*;

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [REG_AW-1:0] dest_q [DEPTH];
  logic [REG_AW-1:0] dest_d [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [DATA_W-1:0] val_d  [DEPTH];

  logic [DEPTH-1:0]        wb_hit;
  logic [DEPTH*DATA_W-1:0] wb_hit_val;
  logic                    alloc_fire, commit_fire;
  logic [TAG_W-1:0]        lt;

  rob_wb_arbiter #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .WB_PORTS(WB_PORTS)
  ) u_wb_arb (
    .wb_valid_i (wb_valid),
    .wb_tag_i   (wb_tag),
    .wb_value_i (wb_value),
    .hit_o      (wb_hit),
    .hit_value_o(wb_hit_val)
  );

  assign empty        = (count_q == '0);
  assign full         = (count_q == (TAG_W+1)'(DEPTH));
  assign alloc_ready  = !full;
  assign alloc_tag    = tail_q;
  assign commit_tag   = head_q;
  assign count        = count_q;
  // A reset or flush cycle must never present a retiring instruction.
  assign commit_valid = !rst && !flush && !empty && done_q[head_q];
  assign commit_we    = commit_valid && (op_q[head_q] != OP_STORE);
  assign commit_dest  = dest_q[head_q];
  assign commit_value = val_q[head_q];
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign commit_fire  = commit_valid && commit_ready;

  // Next state: writeback completion, then retire at head, then allocate at tail.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    op_d    = op_q;
    dest_d  = dest_q;
    val_d   = val_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (wb_hit[e] && busy_q[e] && !done_q[e]) begin
        done_d[e] = 1'b1;
        val_d[e]  = wb_hit_val[e*DATA_W +: DATA_W];
      end
    end
    if (commit_fire) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end
    if (alloc_fire) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      op_d[tail_q]   = alloc_opcode;
      dest_d[tail_q] = alloc_dest;
      val_d[tail_q]  = '0;
      tail_d         = tail_q + 1'b1;
    end
    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Operand lookup with bypass from the writeback bus for not-yet-done entries.
  always_comb begin
    lt         = '0;
    look_done  = '0;
    look_value = '0;
    for (int i = 0; i < 2; i++) begin
      lt = look_tag[i*TAG_W +: TAG_W];
      if (busy_q[lt]) begin
        if (done_q[lt]) begin
          look_done[i]                 = 1'b1;
          look_value[i*DATA_W +: DATA_W] = val_q[lt];
        end else if (wb_hit[lt]) begin
          look_done[i]                 = 1'b1;
          look_value[i*DATA_W +: DATA_W] = wb_hit_val[lt*DATA_W +: DATA_W];
        end
      end
    end
  end

  // State register; reset and flush both return to the empty buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      op_q    <= '{default: '0};
      dest_q  <= '{default: '0};
      val_q   <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      val_q   <= val_d;
    end
  end

endmodule
